io_led_pwm: RTL and testbench

- IO-bus peripheral directly downstream of the LED value register: consumes its 4-bit LED value and drives the physical LED pins.
- Adds per-LED 8-bit PWM dimming, frame-aligned duty update and optional blinking.
- Registers sit on the DMA IO bus. Read data is daisy-chained: own 1-cycle-registered data, else pass-through of upstream data.

---
 rtl/io_led_pwm.sv | 84 ++++++++
 tb/tb_io_led_pwm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/io_led_pwm.sv
// io_led_pwm: per-LED 8-bit PWM dimming with frame-aligned duty update and blinking.
module io_led_pwm #(
  parameter int          PRESCALE  = 16,
  parameter logic [13:0] CTRL_ADR  = 14'h3F81,
  parameter logic [13:0] DUTY_ADR  = 14'h3F82,
  parameter logic [13:0] BLINK_ADR = 14'h3F83
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dma_io_we,
  input  logic [15:2]  dma_io_wadr,
  input  logic [31:0]  dma_io_wdata,
  input  logic [15:2]  dma_io_radr,
  input  logic         dma_io_radr_en,
  input  logic [31:0]  dma_io_rdata_in,
  output logic [31:0]  dma_io_rdata,
  input  logic [3:0]   led_in,
  output logic [3:0]   led_out
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic [2:0]    ctrl;
  logic [31:0]   duty_sh, duty_act;
  logic [15:0]   blink, blink_cnt;
  logic          blink_phase;
  logic          rd_sel;
  logic [31:0]   rd_data, rd_val;
  logic [3:0]    on;
  logic          tick, frame_end, wr_ctrl, wr_duty, wr_blink, rd_hit, phase;
  assign tick      = presc == PW'(PRESCALE - 1);
  assign frame_end = tick & (pwm_cnt == 8'hFF);
  assign wr_ctrl   = dma_io_we & (dma_io_wadr == CTRL_ADR);
  assign wr_duty   = dma_io_we & (dma_io_wadr == DUTY_ADR);
  assign wr_blink  = dma_io_we & (dma_io_wadr == BLINK_ADR);
  assign phase     = ~ctrl[1] | (blink == 16'd0) | blink_phase;
  assign rd_hit    = dma_io_radr_en & (dma_io_radr == CTRL_ADR || dma_io_radr == DUTY_ADR ||
                                       dma_io_radr == BLINK_ADR);
  assign rd_val    = dma_io_radr == CTRL_ADR ? {29'd0, ctrl} :
                     dma_io_radr == DUTY_ADR ? duty_sh : {16'd0, blink};
  assign dma_io_rdata = rd_sel ? rd_data : dma_io_rdata_in;
  // duty 0xFF is forced on so that the full-scale value never shows a one-tick gap
  for (genvar i = 0; i < 4; i++) begin : g_on
    logic [7:0] d;
    assign d     = duty_act[8*i +: 8];
    assign on[i] = ctrl[0] ? led_in[i] & (d == 8'hFF | pwm_cnt < d) & phase : led_in[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      ctrl     <= '0;
      duty_sh  <= '1;
      duty_act <= '1;
      blink    <= '0;
      led_out  <= '0;
      rd_sel   <= 1'b0;
      rd_data  <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      pwm_cnt <= tick ? pwm_cnt + 8'd1 : pwm_cnt;
      if (wr_ctrl) ctrl <= dma_io_wdata[2:0];
      if (wr_duty) duty_sh <= dma_io_wdata;
      if (frame_end) duty_act <= duty_sh;
      if (wr_blink) blink <= dma_io_wdata[15:0];
      led_out <= on ^ {4{ctrl[2]}};
      rd_sel  <= rd_hit;
      rd_data <= rd_hit ? rd_val : rd_data;
    end
  end
  // a BLINK write restarts the blink pattern in the on phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_blink) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_end && blink != 16'd0) begin
      blink_cnt   <= blink_cnt == blink - 16'd1 ? '0 : blink_cnt + 16'd1;
      blink_phase <= blink_cnt == blink - 16'd1 ? ~blink_phase : blink_phase;
    end
  end
endmodule

// File: tb/tb_io_led_pwm.sv
// tb_io_led_pwm: directed checks of io_led_pwm with PRESCALE=1.
module tb_io_led_pwm;
  localparam logic [13:0] CTRL = 14'h3F81, DUTY = 14'h3F82, BLNK = 14'h3F83;
  logic        clk = 0, rst_n = 0, dma_io_we = 0, dma_io_radr_en = 0;
  logic [15:2] dma_io_wadr = '0, dma_io_radr = '0;
  logic [31:0] dma_io_wdata = '0, dma_io_rdata_in = 32'hDEADBEEF, dma_io_rdata;
  logic [3:0]  led_in = '0, led_out;
  logic [7:0]  pcnt;
  logic [31:0] obs;
  int          errors = 0, checks = 0, n;
  int          c[4];

  io_led_pwm #(.PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr),
    .dma_io_wdata(dma_io_wdata), .dma_io_radr(dma_io_radr), .dma_io_radr_en(dma_io_radr_en),
    .dma_io_rdata_in(dma_io_rdata_in), .dma_io_rdata(dma_io_rdata),
    .led_in(led_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  // reference frame position: with PRESCALE=1 the PWM counter advances every clock
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pcnt <= 8'd0;
    else pcnt <= pcnt + 8'd1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    dma_io_we = 1; dma_io_wadr = a; dma_io_wdata = d;
    @(negedge clk);
    dma_io_we = 0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] o);
    dma_io_radr_en = 1; dma_io_radr = a;
    @(negedge clk);
    dma_io_radr_en = 0;
    o = dma_io_rdata;
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    for (int i = 0; i < 600 && pcnt !== v; i++) @(negedge clk);
    chk("wait_pcnt", {24'd0, pcnt}, {24'd0, v});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("reset_led", {28'd0, led_out}, 32'h0);
    chk("passthru_idle", dma_io_rdata, 32'hDEADBEEF);
    led_in = 4'b1010;
    @(negedge clk);
    chk("led_passthru", {28'd0, led_out}, 32'hA);
    wr(CTRL, 32'h4);
    @(negedge clk);
    chk("led_invert", {28'd0, led_out}, 32'h5);
    wr(CTRL, 32'hFFFF_FFFF);
    rd(CTRL, obs);
    chk("ctrl_rd_mask", obs, 32'h7);
    @(negedge clk);
    chk("ctrl_rd_after", dma_io_rdata, 32'hDEADBEEF);
    rd(14'h3F84, obs);
    chk("rd_foreign", obs, 32'hDEADBEEF);
    dma_io_we = 1; dma_io_wadr = BLNK; dma_io_wdata = 32'hABCD_1234;
    dma_io_radr_en = 1; dma_io_radr = BLNK;
    @(negedge clk);
    dma_io_we = 0; dma_io_radr_en = 0;
    chk("rw_same_old", dma_io_rdata, 32'h0);
    rd(BLNK, obs);
    chk("blink_rd_mask", obs, 32'h0000_1234);
    dma_io_radr_en = 1; dma_io_radr = CTRL;
    @(negedge clk);
    dma_io_radr = BLNK;
    chk("b2b_first", dma_io_rdata, 32'h7);
    @(negedge clk);
    dma_io_radr_en = 0;
    chk("b2b_second", dma_io_rdata, 32'h0000_1234);
    wr(BLNK, 32'h0);
    wr(CTRL, 32'h3);
    led_in = 4'hF;
    repeat (300) @(negedge clk);
    chk("pre_reset_led", {28'd0, led_out}, 32'hF);
    rst_n = 0;
    #1;
    chk("async_reset_led", {28'd0, led_out}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    rd(CTRL, obs);
    chk("reset_ctrl", obs, 32'h0);
    rd(DUTY, obs);
    chk("reset_duty", obs, 32'hFFFF_FFFF);
    rd(BLNK, obs);
    chk("reset_blink", obs, 32'h0);
    wr(CTRL, 32'h1);
    wait_cnt(8'd100);
    wr(DUTY, 32'h0);
    rd(DUTY, obs);
    chk("duty_shadow_rd", obs, 32'h0);
    chk("duty_hold_mid", {28'd0, led_out}, 32'hF);
    wait_cnt(8'd255);
    chk("duty_hold_255", {28'd0, led_out}, 32'hF);
    @(negedge clk);
    chk("duty_hold_wrap", {28'd0, led_out}, 32'hF);
    @(negedge clk);
    chk("duty_applied", {28'd0, led_out}, 32'h0);
    wr(DUTY, 32'hFF80_0040);
    repeat (520) @(negedge clk);
    c = '{0, 0, 0, 0};
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 4; j++) c[j] += int'(led_out[j]);
      @(negedge clk);
    end
    chk("pwm_led0", c[0], 64);
    chk("pwm_led1", c[1], 0);
    chk("pwm_led2", c[2], 128);
    chk("pwm_led3", c[3], 256);
    wr(DUTY, 32'hFFFF_FFFF);
    wr(CTRL, 32'h3);
    wr(BLNK, 32'h2);
    for (int i = 0; i < 1200 && led_out !== 4'h0; i++) @(negedge clk);
    chk("blink_fall", {28'd0, led_out}, 32'h0);
    n = 0;
    while (led_out === 4'h0 && n < 600) begin n++; @(negedge clk); end
    chk("blink_off_len", n, 512);
    n = 0;
    while (led_out === 4'hF && n < 600) begin n++; @(negedge clk); end
    chk("blink_on_len", n, 512);
    repeat (100) @(negedge clk);
    chk("blink_mid_off", {28'd0, led_out}, 32'h0);
    wr(BLNK, 32'h2);
    chk("blink_rewrite_lat", {28'd0, led_out}, 32'h0);
    @(negedge clk);
    chk("blink_rewrite_on", {28'd0, led_out}, 32'hF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
